hbridge_pwm_driver: RTL and testbench
=====================================

// Module: hbridge_pwm_driver
// PURPOSE
// - N-channel PWM driver for L293-style H-bridges; replaces the fixed 2-motor controller.
// - Takes a signed duty command (sign + magnitude) per channel and emits enable/INA/INB.
// - Adds an internal prescaler, period-boundary command update, slew-limited duty ramp,
//   direction-change dead time and a selectable brake/coast stop.
// - Sits between the balance control loop and the motor pins, driven by the system clock.
// PARAMETERS
// - NUM_CH    2    number of motor channels
// - DUTY_W    7    duty magnitude width in bits
// - PERIOD    100  PWM ticks per PWM period; requires PERIOD <= 2**DUTY_W
// - PRESCALE  51   clk cycles per PWM tick; must be >= 1
// - DEADTIME  4    full PWM periods with the bridge off on a direction change
// - RAMP_STEP 1    maximum change in active duty per PWM period
// PORTS
// - clk         in   1               system clock
// - reset       in   1               asynchronous, active-high reset
// - cmd_sign    in   NUM_CH          per-channel direction: 1 = forward (INA=1, INB=0)
// - cmd_mag     in   NUM_CH*DUTY_W   per-channel target duty magnitude, channel i at [i*DUTY_W +: DUTY_W]
// - cmd_valid   in   1               one-cycle strobe; captures all cmd_* into pending registers
// - brake_mode  in   1               1 = brake when the target is 0 (en=1, ina=inb=0); 0 = coast
// - en          out  NUM_CH          bridge enable (the PWM output)
// - ina         out  NUM_CH          bridge input A
// - inb         out  NUM_CH          bridge input B
// - period_strb out  1               one-cycle pulse on the clock cycle a PWM period starts
// - dead_busy   out  NUM_CH          channel is in dead time
// BEHAVIOUR
// - Reset (async): all outputs 0; prescaler, PWM counter, pending and active registers cleared;
//   every channel enters IDLE. The same applies when reset is asserted mid-period.
// - Prescaler: counts 0..PRESCALE-1; a tick is asserted when it wraps. The PWM counter
//   pwm_cnt counts 0..PERIOD-1, advancing on each tick.
// - Period boundary (bnd): the tick on which pwm_cnt wraps to 0. period_strb asserts in the
//   same cycle that pwm_cnt becomes 0. After reset the first boundary occurs at the first wrap.
// - Command capture: cmd_valid latches pending_sign and pending_mag.
//   - A capture in the same cycle as bnd takes effect at the following boundary.
//   - Pending values are never applied between boundaries, so output edges are glitch-free.
//   - Multiple strobes within one period: the last one wins.
// - Magnitude saturation: tgt = min(pending_mag, PERIOD).
// - Per-channel FSM, evaluated only at bnd:
//   - IDLE: act_duty = 0.
//     - tgt != 0: set dir = pending_sign and go to RUN.
//   - RUN: act_duty moves toward tgt by at most RAMP_STEP, clamped at tgt.
//     - pending_sign != dir and act_duty != 0: act_duty := 0, dead_cnt := DEADTIME-1, go to DEAD.
//     - tgt == 0 and act_duty == 0 after ramping: go to IDLE.
//   - DEAD: dead_cnt decrements.
//     - When dead_cnt == 0: dir := pending_sign, go to RUN (or IDLE if tgt == 0); the ramp restarts from 0.
//     - Sign changes during DEAD do not restart the timer.
// - Outputs are registered and depend only on the state and counter values after each edge:
//   - RUN:            en = (pwm_cnt < act_duty); ina = dir; inb = ~dir.
//   - DEAD:           en = 0; ina = 0; inb = 0; dead_busy = 1.
//   - IDLE, coast:    en = 0; ina = 0; inb = 0.
//   - IDLE, brake:    en = 1; ina = 0; inb = 0. brake_mode is sampled at bnd.
// - Duty semantics: act_duty = PERIOD gives en constantly high; act_duty = 0 gives en low.
// - ina and inb are never both 1 in any cycle.
// - Width rules: pwm_cnt is $clog2(PERIOD) bits. The act_duty ramp saturates at 0 and at PERIOD,
//   so the ramp never wraps.
// STRUCTURE
// - Package motor_pkg holds:
//   - typedef enum logic [1:0] {IDLE, RUN, DEAD} ch_state_t
//   - default constants for PERIOD, PRESCALE, DEADTIME
// - Sub-module hbridge_channel: per-channel FSM, ramp, dead counter and compare.
//   It is instantiated NUM_CH times in a generate loop.
// - The top level owns the prescaler, pwm_cnt, bnd/period_strb and the pending registers.
// TESTING
// - Common settings: PRESCALE=1, PERIOD=100, RAMP_STEP=1, DEADTIME=4.
// - Reset: assert reset mid-period with ch0 in RUN -> en, ina, inb, dead_busy go to 0
//   without waiting for a clk edge; after release, the first period_strb arrives after PERIOD ticks.
// - Ramp: cmd ch0 = +50 -> act_duty goes 1, 2, ... 50 over 50 periods, then stays at 50;
//   en is high for exactly 50 of 100 ticks, with ina=1 and inb=0.
// - Saturation and timing: cmd_mag = 127 (PERIOD=100, RAMP_STEP=127) -> en high for every
//   tick of the period. The same strobe issued in the bnd cycle takes effect one period later.
// - Direction change: ch0 at +30, then cmd -30 -> en=ina=inb=0 and dead_busy=1 for 4 periods,
//   then inb=1 and the ramp restarts from 1.
// - Stop modes: cmd 0 at act_duty = 3 -> ramps 2, 1, 0, then IDLE.
//   - brake_mode=1: en=1, ina=inb=0.
//   - brake_mode=0: all outputs 0.
// - Channel independence (NUM_CH=2): ch0 = +20 and ch1 = -100 run concurrently with no
//   interaction; ina&inb is never 1 on either channel.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared channel state type and default timing constants for the H-bridge PWM driver.
package motor_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} ch_state_t;

  localparam int DEF_PERIOD   = 100;
  localparam int DEF_PRESCALE = 51;
  localparam int DEF_DEADTIME = 4;

endpackage

// File: rtl/hbridge_channel.sv
// One H-bridge channel: boundary-evaluated FSM, slew-limited duty ramp, dead-time
// counter and registered PWM compare driving en/ina/inb.
module hbridge_channel
  import motor_pkg::*;
#(
  parameter int DUTY_W    = 7,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int DEADTIME  = DEF_DEADTIME,
  parameter int RAMP_STEP = 1,
  parameter int CNT_W     = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bnd_i,
  input  logic              sign_i,
  input  logic [DUTY_W:0]   tgt_i,
  input  logic [CNT_W-1:0]  cnt_nxt_i,
  input  logic              brake_nxt_i,
  output logic              en_o,
  output logic              ina_o,
  output logic              inb_o,
  output logic              dead_busy_o
);

  localparam int AW = DUTY_W + 1;
  localparam int DW = $clog2(DEADTIME + 1);

  ch_state_t         state_q, state_d;
  logic [AW-1:0]     act_q, act_d;
  logic              dir_q, dir_d;
  logic [DW-1:0]     dead_q, dead_d;
  logic              en_q, en_d, ina_q, ina_d, inb_q, inb_d, busy_q, busy_d;

  // Arithmetic is done in 32 bits so the step can never wrap past 0 or PERIOD.
  function automatic logic [AW-1:0] ramp_toward(input logic [AW-1:0] cur, input logic [AW-1:0] tgt);
    int unsigned c, t;
    c = 32'(cur);
    t = 32'(tgt);
    if (c < t) return (t - c > RAMP_STEP) ? AW'(c + RAMP_STEP) : tgt;
    return (c - t > RAMP_STEP) ? AW'(c - RAMP_STEP) : tgt;
  endfunction

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    if (bnd_i) begin
      case (state_q)
        IDLE: begin
          act_d = '0;
          if (tgt_i != '0) begin
            dir_d   = sign_i;
            act_d   = ramp_toward('0, tgt_i);
            state_d = RUN;
          end
        end
        RUN: begin
          if (sign_i != dir_q && act_q != '0) begin
            act_d   = '0;
            dead_d  = DW'(DEADTIME - 1);
            state_d = DEAD;
          end else begin
            act_d = ramp_toward(act_q, tgt_i);
            if (tgt_i == '0 && act_d == '0) state_d = IDLE;
          end
        end
        DEAD: begin
          if (dead_q == '0) begin
            dir_d   = sign_i;
            act_d   = ramp_toward('0, tgt_i);
            state_d = (tgt_i == '0) ? IDLE : RUN;
          end else begin
            dead_d = dead_q - DW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are computed from the post-edge state and counter so they are glitch-free registers.
  always_comb begin
    en_d   = 1'b0;
    ina_d  = 1'b0;
    inb_d  = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      RUN: begin
        en_d  = (AW'(cnt_nxt_i) < act_d);
        ina_d = dir_d;
        inb_d = ~dir_d;
      end
      DEAD:    busy_d = 1'b1;
      default: en_d = brake_nxt_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      act_q   <= '0;
      dir_q   <= 1'b0;
      dead_q  <= '0;
      en_q    <= 1'b0;
      ina_q   <= 1'b0;
      inb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      en_q    <= en_d;
      ina_q   <= ina_d;
      inb_q   <= inb_d;
      busy_q  <= busy_d;
    end
  end

  assign en_o        = en_q;
  assign ina_o       = ina_q;
  assign inb_o       = inb_q;
  assign dead_busy_o = busy_q;

endmodule

// File: rtl/hbridge_pwm_driver.sv
// N-channel H-bridge PWM driver: shared prescaler, PWM counter, period strobe and
// pending command registers feeding one hbridge_channel per motor.
module hbridge_pwm_driver
  import motor_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DUTY_W    = 7,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int DEADTIME  = DEF_DEADTIME,
  parameter int RAMP_STEP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        cmd_sign,
  input  logic [NUM_CH*DUTY_W-1:0] cmd_mag,
  input  logic                     cmd_valid,
  input  logic                     brake_mode,
  output logic [NUM_CH-1:0]        en,
  output logic [NUM_CH-1:0]        ina,
  output logic [NUM_CH-1:0]        inb,
  output logic                     period_strb,
  output logic [NUM_CH-1:0]        dead_busy
);

  localparam int AW    = DUTY_W + 1;
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]          presc_q, presc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     tick, bnd;
  logic                     strb_q;
  logic                     brake_q, brake_d;
  logic [NUM_CH-1:0]        pend_sign_q;
  logic [NUM_CH*DUTY_W-1:0] pend_mag_q;

  assign tick = (presc_q == PS_W'(PRESCALE - 1));
  assign bnd  = tick && (cnt_q == CNT_W'(PERIOD - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PS_W'(1);
    cnt_d   = cnt_q;
    if (bnd)       cnt_d = '0;
    else if (tick) cnt_d = cnt_q + CNT_W'(1);
    brake_d = bnd ? brake_mode : brake_q;
  end

  // A strobe coinciding with bnd lands after the channels have sampled the old pending values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      strb_q      <= 1'b0;
      brake_q     <= 1'b0;
      pend_sign_q <= '0;
      pend_mag_q  <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      strb_q  <= bnd;
      brake_q <= brake_d;
      if (cmd_valid) begin
        pend_sign_q <= cmd_sign;
        pend_mag_q  <= cmd_mag;
      end
    end
  end

  assign period_strb = strb_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DUTY_W-1:0] mag;
    logic [AW-1:0]     tgt;

    assign mag = pend_mag_q[gi*DUTY_W +: DUTY_W];
    assign tgt = ({1'b0, mag} > AW'(PERIOD)) ? AW'(PERIOD) : {1'b0, mag};

    hbridge_channel #(
      .DUTY_W    (DUTY_W),
      .PERIOD    (PERIOD),
      .DEADTIME  (DEADTIME),
      .RAMP_STEP (RAMP_STEP),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk_i       (clk),
      .rst_i       (reset),
      .bnd_i       (bnd),
      .sign_i      (pend_sign_q[gi]),
      .tgt_i       (tgt),
      .cnt_nxt_i   (cnt_d),
      .brake_nxt_i (brake_d),
      .en_o        (en[gi]),
      .ina_o       (ina[gi]),
      .inb_o       (inb[gi]),
      .dead_busy_o (dead_busy[gi])
    );
  end

endmodule

// File: tb/tb_hbridge_pwm_driver.sv
// Bench for hbridge_pwm_driver: a period-level behavioural model checked every cycle,
// plus directed per-period tick counts computed by hand.
module tb_hbridge_pwm_driver;

  localparam int NCH  = 2;
  localparam int DW   = 7;
  localparam int P    = 100;
  localparam int DT   = 4;
  localparam int STEP = 1;
  localparam int MI = 0, MR = 1, MD = 2;

  logic            clk        = 1'b0;
  logic            reset      = 1'b1;
  logic [NCH-1:0]  cmd_sign   = '0;
  logic [NCH*DW-1:0] cmd_mag  = '0;
  logic            cmd_valid  = 1'b0;
  logic            brake_mode = 1'b0;
  logic [NCH-1:0]  en, ina, inb, dead_busy;
  logic            period_strb;

  hbridge_pwm_driver #(
    .NUM_CH(NCH), .DUTY_W(DW), .PERIOD(P), .PRESCALE(1), .DEADTIME(DT), .RAMP_STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .cmd_sign(cmd_sign), .cmd_mag(cmd_mag), .cmd_valid(cmd_valid),
    .brake_mode(brake_mode), .en(en), .ina(ina), .inb(inb), .period_strb(period_strb),
    .dead_busy(dead_busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Behavioural model: PWM position, pending command, and per-channel mode/duty/direction.
  int m_cnt;
  bit m_strb, m_brake;
  bit m_psign [NCH];
  int m_pmag  [NCH];
  int m_mode  [NCH];
  int m_duty  [NCH];
  int m_dead  [NCH];
  bit m_dir   [NCH];

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return (cur + STEP < tgt) ? cur + STEP : tgt;
    return (cur - STEP > tgt) ? cur - STEP : tgt;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_strb = 0; m_brake = 0;
    for (int c = 0; c < NCH; c++) begin
      m_psign[c] = 0; m_pmag[c] = 0; m_mode[c] = MI; m_duty[c] = 0; m_dead[c] = 0; m_dir[c] = 0;
    end
  endtask

  task automatic model_boundary();
    for (int c = 0; c < NCH; c++) begin
      int tgt;
      tgt = (m_pmag[c] > P) ? P : m_pmag[c];
      case (m_mode[c])
        MI: if (tgt != 0) begin
          m_dir[c] = m_psign[c]; m_duty[c] = toward(0, tgt); m_mode[c] = MR;
        end
        MR: if (m_psign[c] != m_dir[c] && m_duty[c] != 0) begin
          m_duty[c] = 0; m_dead[c] = DT; m_mode[c] = MD;
        end else begin
          m_duty[c] = toward(m_duty[c], tgt);
          if (tgt == 0 && m_duty[c] == 0) m_mode[c] = MI;
        end
        default: begin
          m_dead[c]--;
          if (m_dead[c] == 0) begin
            m_dir[c] = m_psign[c]; m_duty[c] = toward(0, tgt); m_mode[c] = (tgt == 0) ? MI : MR;
          end
        end
      endcase
    end
  endtask

  function automatic logic [3:0] exp_outs(input int c);
    case (m_mode[c])
      MR:      return {m_cnt < m_duty[c], m_dir[c], ~m_dir[c], 1'b0};
      MD:      return 4'b0001;
      default: return {m_brake, 3'b000};
    endcase
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_clear();
      end else begin
        if (m_cnt == P - 1) begin
          model_boundary();
          m_brake = brake_mode;
          m_cnt = 0;
          m_strb = 1;
        end else begin
          m_cnt++;
          m_strb = 0;
        end
        if (cmd_valid)
          for (int c = 0; c < NCH; c++) begin
            m_psign[c] = cmd_sign[c];
            m_pmag[c]  = int'(cmd_mag[c*DW +: DW]);
          end
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    chk($sformatf("period_strb @cnt %0d", m_cnt), period_strb, m_strb);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("ch%0d {en,ina,inb,busy} @cnt %0d", c, m_cnt),
          {en[c], ina[c], inb[c], dead_busy[c]}, exp_outs(c));
      chk($sformatf("ch%0d ina&inb", c), ina[c] & inb[c], 1'b0);
    end
  end

  int meas_en [NCH], meas_ina [NCH], meas_inb [NCH], meas_busy [NCH];

  task automatic wait_strb();
    int n;
    n = 0;
    while (period_strb !== 1'b1 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    chk("period_strb within budget", period_strb, 1'b1);
  endtask

  // Counts high ticks of each output over one full period starting at a strobe.
  task automatic measure();
    wait_strb();
    for (int c = 0; c < NCH; c++) begin
      meas_en[c] = 0; meas_ina[c] = 0; meas_inb[c] = 0; meas_busy[c] = 0;
    end
    for (int i = 0; i < P; i++) begin
      for (int c = 0; c < NCH; c++) begin
        meas_en[c]   += int'(en[c]);
        meas_ina[c]  += int'(ina[c]);
        meas_inb[c]  += int'(inb[c]);
        meas_busy[c] += int'(dead_busy[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_meas(input string tag, input int c, input int e_en, input int e_ina,
                            input int e_inb, input int e_busy);
    chk($sformatf("%s ch%0d en ticks", tag, c), meas_en[c], e_en);
    chk($sformatf("%s ch%0d ina ticks", tag, c), meas_ina[c], e_ina);
    chk($sformatf("%s ch%0d inb ticks", tag, c), meas_inb[c], e_inb);
    chk($sformatf("%s ch%0d dead_busy ticks", tag, c), meas_busy[c], e_busy);
  endtask

  task automatic expect_period(input string tag, input int c, input int e_en, input int e_ina,
                               input int e_inb, input int e_busy);
    measure();
    check_meas(tag, c, e_en, e_ina, e_inb, e_busy);
  endtask

  task automatic send(input logic [NCH-1:0] s, input logic [DW-1:0] m0, input logic [DW-1:0] m1);
    cmd_sign  = s;
    cmd_mag   = {m1, m0};
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic count_to_first_strobe(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_strb !== 1'b1 && n < 3 * P);
    chk(tag, n, P);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset en", en, 0);
    chk("reset ina", ina, 0);
    chk("reset inb", inb, 0);
    chk("reset dead_busy", dead_busy, 0);
    chk("reset period_strb", period_strb, 0);
    reset = 1'b0;
    count_to_first_strobe("cycles to first strobe");

    // Ramp to +50 on ch0.
    send(2'b01, 7'd50, 7'd0);
    expect_period("ramp p1", 0, 1, P, 0, 0);
    check_meas("ramp p1", 1, 0, 0, 0, 0);
    expect_period("ramp p2", 0, 2, P, 0, 0);
    repeat (47) measure();
    expect_period("ramp p50", 0, 50, P, 0, 0);
    expect_period("ramp hold", 0, 50, P, 0, 0);

    // Ramp down to +30, then reverse.
    send(2'b01, 7'd30, 7'd0);
    repeat (19) measure();
    expect_period("down to 30", 0, 30, P, 0, 0);
    send(2'b00, 7'd30, 7'd0);
    for (int k = 0; k < DT; k++) expect_period($sformatf("dead %0d", k), 0, 0, 0, 0, P);
    expect_period("reverse p1", 0, 1, 0, P, 0);

    // Stop command issued in the boundary cycle: one more ramp step, then 2, 1, brake.
    repeat (P - 1) @(negedge clk);
    brake_mode = 1'b1;
    send(2'b00, 7'd0, 7'd0);
    expect_period("bnd-cycle cmd delayed", 0, 3, 0, P, 0);
    check_meas("bnd-cycle brake idle", 1, P, 0, 0, 0);
    expect_period("stop 2", 0, 2, 0, P, 0);
    expect_period("stop 1", 0, 1, 0, P, 0);
    expect_period("brake", 0, P, 0, 0, 0);
    brake_mode = 1'b0;
    expect_period("brake until bnd", 0, P, 0, 0, 0);
    expect_period("coast", 0, 0, 0, 0, 0);

    // Two channels together; ch1 magnitude saturates at PERIOD.
    send(2'b01, 7'd20, 7'd127);
    measure();
    check_meas("indep p1", 0, 1, P, 0, 0);
    check_meas("indep p1", 1, 1, 0, P, 0);
    repeat (98) measure();
    measure();
    check_meas("indep p100", 0, 20, P, 0, 0);
    check_meas("indep p100", 1, P, 0, P, 0);
    measure();
    check_meas("saturated", 1, P, 0, P, 0);

    // Asynchronous reset mid-period.
    repeat (40) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async reset en", en, 0);
    chk("async reset ina", ina, 0);
    chk("async reset inb", inb, 0);
    chk("async reset dead_busy", dead_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    count_to_first_strobe("cycles to strobe after mid reset");
    expect_period("idle after reset", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
